// File: rtl/sysarray_nxn.sv
// N x N output-stationary systolic matrix multiply with input skew, job FSM and valid/ready feed.
// Define SYSARRAY_SAT_EN to make accumulators saturate instead of wrapping.
module sysarray_nxn #(
  parameter int unsigned N     = 3,
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 8,
  parameter int unsigned ACC_W = 18,
  parameter int unsigned K_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [K_W-1:0]          k_len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   a_col [0:N-1],
  input  logic signed [B_W-1:0]   b_row [0:N-1],
  output logic                    done,
  output logic signed [ACC_W-1:0] out   [0:N-1][0:N-1]
);

  localparam int unsigned P_W   = A_W + B_W;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned FL_W  = $clog2(2 * N);
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(2 * N - 2);

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StFlush, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [K_W-1:0]   r_k, r_beat;
  logic [FL_W-1:0]  r_flush;
  logic             w_clear, w_accept, w_last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  assign w_accept    = in_valid & in_ready;
  assign w_last_beat = (r_beat == r_k - K_W'(1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StClear;
      StClear: w_state_next = (r_k != '0) ? StFeed : StDone;
      StFeed:  if (w_accept && w_last_beat) w_state_next = StFlush;
      StFlush: if (r_flush == FLUSH_LAST) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    w_clear  = 1'b0;
    unique case (r_state)
      StIdle:  ;
      StClear: begin busy = 1'b1; w_clear = 1'b1; end
      StFeed:  begin busy = 1'b1; in_ready = 1'b1; end
      StFlush: busy = 1'b1;
      StDone:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_beat  <= '0;
      r_flush <= '0;
    end else begin
      if (r_state == StIdle && start) r_k <= k_len;
      if (w_clear)       r_beat <= '0;
      else if (w_accept) r_beat <= r_beat + K_W'(1);
      if (r_state == StFlush) r_flush <= r_flush + FL_W'(1);
      else                    r_flush <= '0;
    end
  end

  // Non-accepted cycles push zeros so bubbles never contribute to the sums.
  logic signed [A_W-1:0] w_a_inj  [0:N-1];
  logic signed [A_W-1:0] w_a_edge [0:N-1];
  logic signed [B_W-1:0] w_b_inj  [0:N-1];
  logic signed [B_W-1:0] w_b_edge [0:N-1];

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    assign w_a_inj[gi] = w_accept ? a_col[gi] : '0;
    assign w_b_inj[gi] = w_accept ? b_row[gi] : '0;
    if (gi == 0) begin : g_direct
      assign w_a_edge[gi] = w_a_inj[gi];
      assign w_b_edge[gi] = w_b_inj[gi];
    end else begin : g_delay
      logic signed [A_W-1:0] r_a_sk [0:gi-1];
      logic signed [B_W-1:0] r_b_sk [0:gi-1];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < gi; s++) begin
            r_a_sk[s] <= '0;
            r_b_sk[s] <= '0;
          end
        end else begin
          r_a_sk[0] <= w_a_inj[gi];
          r_b_sk[0] <= w_b_inj[gi];
          for (int s = 1; s < gi; s++) begin
            r_a_sk[s] <= r_a_sk[s-1];
            r_b_sk[s] <= r_b_sk[s-1];
          end
        end
      end
      assign w_a_edge[gi] = r_a_sk[gi-1];
      assign w_b_edge[gi] = r_b_sk[gi-1];
    end
  end

  logic signed [A_W-1:0] w_a_fwd [0:N-1][0:N-2];
  logic signed [B_W-1:0] w_b_fwd [0:N-2][0:N-1];

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [A_W-1:0]   w_a;
      logic signed [B_W-1:0]   w_b;
      logic signed [P_W-1:0]   w_a_x, w_b_x, w_prod;
      logic signed [ACC_W-1:0] r_acc, w_acc_next;

      if (gj == 0) begin : g_a_edge
        assign w_a = w_a_edge[gi];
      end else begin : g_a_left
        assign w_a = w_a_fwd[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign w_b = w_b_edge[gj];
      end else begin : g_b_up
        assign w_b = w_b_fwd[gi-1][gj];
      end

      // The last column/row has no neighbour, so its forwarding register is not built.
      if (gj < N - 1) begin : g_a_reg
        logic signed [A_W-1:0] r_a;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_a <= '0;
          else     r_a <= w_a;
        end
        assign w_a_fwd[gi][gj] = r_a;
      end
      if (gi < N - 1) begin : g_b_reg
        logic signed [B_W-1:0] r_b;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_b <= '0;
          else     r_b <= w_b;
        end
        assign w_b_fwd[gi][gj] = r_b;
      end

      assign w_a_x  = {{B_W{w_a[A_W-1]}}, w_a};
      assign w_b_x  = {{A_W{w_b[B_W-1]}}, w_b};
      assign w_prod = w_a_x * w_b_x;

`ifdef SYSARRAY_SAT_EN
      logic signed [SUM_W-1:0] w_sum;
      assign w_sum = SUM_W'(r_acc) + SUM_W'(w_prod);
      always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
          w_acc_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
      end
`else
      assign w_acc_next = r_acc + ACC_W'(w_prod);
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_acc <= '0;
        else if (w_clear) r_acc <= '0;
        else              r_acc <= w_acc_next;
      end

      assign out[gi][gj] = r_acc;
    end
  end

endmodule

// File: tb/tb_sysarray_nxn.sv
// Table-driven bench for sysarray_nxn (N=3): job records with expected results and done cycle.
module tb_sysarray_nxn;

  localparam int N = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [7:0]               k_len;
  logic                     busy, in_ready, done;
  logic                     in_valid;
  logic signed [7:0]        a_col [0:N-1];
  logic signed [7:0]        b_row [0:N-1];
  logic signed [17:0]       out_w [0:N-1][0:N-1];

  always #5 clk = ~clk;

  sysarray_nxn #(.N(3), .A_W(8), .B_W(8), .ACC_W(18), .K_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_col    (a_col),
    .b_row    (b_row),
    .done     (done),
    .out      (out_w)
  );

  // pat: 0 = identity A with B = 1..9, 1 = all -128, 2 = all ones
  typedef struct packed {
    logic [7:0]       k;
    logic [3:0]       gap;
    logic [1:0]       pat;
    logic [7:0]       pulse;
    logic [7:0]       exp_done;
    logic [8:0][17:0] exp;
  } vec_t;

  localparam logic [8:0][17:0] MAT_B = {18'd9, 18'd8, 18'd7, 18'd6, 18'd5, 18'd4, 18'd3, 18'd2, 18'd1};
`ifdef SYSARRAY_SAT_EN
  localparam logic [17:0] K8_VAL = 18'h1FFFF;  // +131071 clamped
`else
  localparam logic [17:0] K8_VAL = 18'h20000;  // -131072 after wrap
`endif

  vec_t vecs [0:5];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic logic [8:0][17:0] uni(input logic [17:0] v);
    return {9{v}};
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  task automatic set_ops(input int pat, input int kk);
    for (int i = 0; i < N; i++) begin
      case (pat)
        0: begin a_col[i] = (i == kk) ? 8'sd1 : 8'sd0; b_row[i] = 8'(3 * kk + i + 1); end
        1: begin a_col[i] = 8'h80; b_row[i] = 8'h80; end
        2: begin a_col[i] = 8'sd1; b_row[i] = 8'sd1; end
        default: begin a_col[i] = 8'sd99; b_row[i] = -8'sd77; end
      endcase
    end
  endtask

  task automatic check_out(input string nm, input logic [8:0][17:0] exp);
    int bad = 0;
    for (int n = N * N - 1; n >= 0; n--) begin
      if (longint'(out_w[n / N][n % N]) != longint'($signed(exp[n]))) bad = n;
    end
    chk(nm, longint'(out_w[bad / N][bad % N]), longint'($signed(exp[bad])));
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int beat = 0;
    int gap = int'(v.gap);
    int done_cyc = -1;
    int busy_n = 0;
    int rdy_n = 0;
    int rdy_first = -1;
    int busy_after = 0;
    @(negedge clk);
    start = 1'b1; k_len = v.k; in_valid = 1'b0; set_ops(3, 0);
    for (int c = 1; c < 80 && done_cyc < 0; c++) begin
      @(negedge clk);
      start = (c == int'(v.pulse));
      if (busy) busy_n++;
      if (in_ready) begin
        rdy_n++;
        if (rdy_first < 0) rdy_first = c;
      end
      if (done) done_cyc = c;
      in_valid = 1'b0; set_ops(3, 0);
      if (in_ready && beat < int'(v.k)) begin
        if (beat == 1 && gap > 0) gap--;
        else begin
          in_valid = 1'b1; set_ops(int'(v.pat), beat); beat++;
        end
      end
    end
    chk({tag, "_done_cycle"}, done_cyc, int'(v.exp_done));
    check_out({tag, "_out"}, v.exp);
    chk({tag, "_busy_cycles"}, busy_n, int'(v.exp_done));
    chk({tag, "_ready_cycles"}, rdy_n, int'(v.k) + int'(v.gap));
    if (v.k != 0) chk({tag, "_ready_first"}, rdy_first, 2);
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (busy || done) busy_after++;
    end
    chk({tag, "_idle_after"}, busy_after, 0);
    check_out({tag, "_out_hold"}, v.exp);
  endtask

  initial begin
    vecs[0] = '{k: 8'd3, gap: 4'd0, pat: 2'd0, pulse: 8'd0, exp_done: 8'd10, exp: MAT_B};
    vecs[1] = '{k: 8'd3, gap: 4'd0, pat: 2'd1, pulse: 8'd0, exp_done: 8'd10, exp: uni(18'd49152)};
    vecs[2] = '{k: 8'd1, gap: 4'd0, pat: 2'd2, pulse: 8'd5, exp_done: 8'd8,  exp: uni(18'd1)};
    vecs[3] = '{k: 8'd8, gap: 4'd0, pat: 2'd1, pulse: 8'd0, exp_done: 8'd15, exp: uni(K8_VAL)};
    vecs[4] = '{k: 8'd3, gap: 4'd2, pat: 2'd0, pulse: 8'd0, exp_done: 8'd12, exp: MAT_B};
    vecs[5] = '{k: 8'd0, gap: 4'd0, pat: 2'd0, pulse: 8'd0, exp_done: 8'd2,  exp: uni(18'd0)};

    rst = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; set_ops(3, 0);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_in_ready", longint'(in_ready), 0);
    chk("reset_done", longint'(done), 0);
    check_out("reset_out", uni(18'd0));
    rst = 1'b0;

    for (int t = 0; t < 6; t++) run_job(vecs[t], $sformatf("job%0d", t));

    // Asynchronous reset in the middle of FEED, between clock edges.
    @(negedge clk); start = 1'b1; k_len = 8'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk); in_valid = 1'b1; set_ops(0, 0);
    @(negedge clk); set_ops(0, 1);
    chk("prereset_acc00", longint'(out_w[0][0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_in_ready", longint'(in_ready), 0);
    chk("midrst_done", longint'(done), 0);
    check_out("midrst_out", uni(18'd0));
    in_valid = 1'b0; set_ops(3, 0);
    @(negedge clk); rst = 1'b0;
    run_job(vecs[0], "rerun");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
